// File: rtl/mbox_pkg.sv
// Shared types and constants for the MBOX cycle responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mbox_pkg;

    localparam int MBOX_ADDR_W = 23;
    localparam int MBOX_DATA_W = 36;

    // Responder sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_RESP,
        ST_PAUSED,
        ST_WR,
        ST_WR_RESP,
        ST_FAIL
    } mbox_state_t;

    // Kind of memory cycle requested by the EBOX
    typedef enum logic [1:0] {
        CYC_RD,
        CYC_WR,
        CYC_RPW,
        CYC_NOP
    } mbox_cyc_t;

    // Read takes priority; a read with pause+write becomes read-pause-write
    function automatic mbox_cyc_t decode_cyc(input logic rd, input logic wr, input logic pause);
        mbox_cyc_t c;
        if (rd)
            c = (pause && wr) ? CYC_RPW : CYC_RD;
        else if (wr)
            c = CYC_WR;
        else
            c = CYC_NOP;
        return c;
    endfunction

endpackage

// File: rtl/mbox_nxm_timer.sv
// Wait-cycle counter that flags a non-existent-memory timeout.
// Latency: expire is combinational in the LIMIT-th counted cycle.
// Backpressure: none; counts whenever count=1, cleared by clear=1.
module mbox_nxm_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic RESET,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Count un-acknowledged wait cycles; restart whenever no access is pending
    always_ff @(posedge clk) begin
        if (RESET || clear)
            cnt <= '0;
        else if (count)
            cnt <= cnt + 1'b1;
    end

    // The cycle that would bring the count up to LIMIT is the timeout cycle
    assign expire = count && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mbox_cyc_resp.sv
// MBOX responder: runs one EBOX memory cycle (read / write / read-pause-write) on a simple memory port.
// Latency: response 2 cycles after request with zero-wait memory, +1 per memory wait cycle.
// Backpressure: MEM_REQ held until MEM_ACK; requests while BUSY are dropped. Build option MBOX_NXM_TIMEOUT_EN adds NXM timeout.
module mbox_cyc_resp
    import mbox_pkg::*;
#(
    parameter int ADDR_W    = MBOX_ADDR_W,
    parameter int DATA_W    = MBOX_DATA_W,
    parameter int NXM_LIMIT = 255
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              MBOX_CYC_REQ,
    input  logic              VMA_READ,
    input  logic              VMA_WRITE,
    input  logic              VMA_PAUSE,
    input  logic              LOAD_AR,
    input  logic              LOAD_ARX,
    input  logic              VMA_FETCH,
    input  logic              VMA_ADR_ERR,
    input  logic [ADDR_W-1:0] VMA,
    input  logic [DATA_W-1:0] AR_DATA,
    output logic              MBOX_RESP,
    output logic [DATA_W-1:0] MBOX_DATA,
    output logic              AR_LOAD,
    output logic              ARX_LOAD,
    output logic              FETCH_DONE,
    output logic              PAGE_FAIL,
    output logic              NXM,
    output logic              BUSY,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    mbox_state_t state, state_nxt;
    mbox_cyc_t   req_cyc;
    mbox_cyc_t   cyc;
    logic        ld_ar, ld_arx, fetch;
    logic        nxm_expire;

    assign req_cyc = decode_cyc(VMA_READ, VMA_WRITE, VMA_PAUSE);

`ifdef MBOX_NXM_TIMEOUT_EN
    logic nxm_q;

    mbox_nxm_timer #(
        .LIMIT (NXM_LIMIT)
    ) u_nxm_timer (
        .clk    (clk),
        .RESET  (RESET),
        .clear  (!MEM_REQ),
        .count  (MEM_REQ && !MEM_ACK),
        .expire (nxm_expire)
    );

    // NXM is reported in the cycle after the timed-out access is abandoned
    always_ff @(posedge clk) begin
        if (RESET)
            nxm_q <= 1'b0;
        else
            nxm_q <= nxm_expire;
    end

    assign NXM = nxm_q;
`else
    // Without the timeout an access waits for MEM_ACK indefinitely
    assign nxm_expire = 1'b0;
    assign NXM        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and Moore output decode
    always_comb begin
        state_nxt  = state;
        MBOX_RESP  = 1'b0;
        AR_LOAD    = 1'b0;
        ARX_LOAD   = 1'b0;
        FETCH_DONE = 1'b0;
        PAGE_FAIL  = 1'b0;
        MEM_REQ    = 1'b0;
        MEM_WE     = 1'b0;
        BUSY       = 1'b1;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (MBOX_CYC_REQ) begin
                    if (VMA_ADR_ERR)
                        state_nxt = ST_FAIL;
                    else begin
                        case (req_cyc)
                            CYC_RD, CYC_RPW: state_nxt = ST_RD;
                            CYC_WR:          state_nxt = ST_WR;
                            // Empty cycle: acknowledge without touching memory
                            default:         state_nxt = ST_WR_RESP;
                        endcase
                    end
                end
            end
            ST_RD: begin
                MEM_REQ = 1'b1;
                if (MEM_ACK)
                    state_nxt = ST_RD_RESP;
                else if (nxm_expire)
                    state_nxt = ST_IDLE;
            end
            ST_RD_RESP: begin
                MBOX_RESP  = 1'b1;
                AR_LOAD    = ld_ar;
                ARX_LOAD   = ld_arx;
                FETCH_DONE = fetch;
                state_nxt  = (cyc == CYC_RPW) ? ST_PAUSED : ST_IDLE;
            end
            ST_PAUSED: begin
                BUSY = 1'b0;
                // Address errors are irrelevant here: the address was checked on the read
                if (MBOX_CYC_REQ)
                    state_nxt = ST_WR;
            end
            ST_WR: begin
                MEM_REQ = 1'b1;
                MEM_WE  = 1'b1;
                if (MEM_ACK)
                    state_nxt = ST_WR_RESP;
                else if (nxm_expire)
                    state_nxt = ST_IDLE;
            end
            ST_WR_RESP: begin
                MBOX_RESP = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_FAIL: begin
                PAGE_FAIL = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latches and read-data capture; only change while no access is pending
    always_ff @(posedge clk) begin
        if (RESET) begin
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MBOX_DATA <= '0;
            ld_ar     <= 1'b0;
            ld_arx    <= 1'b0;
            fetch     <= 1'b0;
            cyc       <= CYC_NOP;
        end else begin
            if (state == ST_IDLE && MBOX_CYC_REQ) begin
                MEM_ADDR  <= VMA;
                MEM_WDATA <= AR_DATA;
                ld_ar     <= LOAD_AR;
                ld_arx    <= LOAD_ARX;
                fetch     <= VMA_FETCH;
                cyc       <= req_cyc;
            end
            // Second half of RPW: new write data, original address kept
            if (state == ST_PAUSED && MBOX_CYC_REQ)
                MEM_WDATA <= AR_DATA;
            if (state == ST_RD) begin
                if (MEM_ACK)
                    MBOX_DATA <= MEM_RDATA;
                else if (nxm_expire)
                    MBOX_DATA <= '1;
            end
        end
    end

endmodule

// File: tb/tb_mbox_cyc_resp.sv
// Scoreboard bench for mbox_cyc_resp: directed cycles push expected events, a monitor checks them.
// Latency: expected event cycle is recorded per request and compared.
// Backpressure: memory acknowledge timing is driven directly by each directed test.
module tb_mbox_cyc_resp;

    localparam int AW = 23;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          RESET;
    logic          MBOX_CYC_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE;
    logic          LOAD_AR, LOAD_ARX, VMA_FETCH, VMA_ADR_ERR;
    logic [AW-1:0] VMA;
    logic [DW-1:0] AR_DATA;
    logic          MBOX_RESP;
    logic [DW-1:0] MBOX_DATA;
    logic          AR_LOAD, ARX_LOAD, FETCH_DONE, PAGE_FAIL, NXM, BUSY;
    logic          MEM_REQ, MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_ACK;
    logic [DW-1:0] MEM_RDATA;

    mbox_cyc_resp #(.ADDR_W(AW), .DATA_W(DW), .NXM_LIMIT(4)) dut (
        .clk(clk), .RESET(RESET), .MBOX_CYC_REQ(MBOX_CYC_REQ),
        .VMA_READ(VMA_READ), .VMA_WRITE(VMA_WRITE), .VMA_PAUSE(VMA_PAUSE),
        .LOAD_AR(LOAD_AR), .LOAD_ARX(LOAD_ARX), .VMA_FETCH(VMA_FETCH),
        .VMA_ADR_ERR(VMA_ADR_ERR), .VMA(VMA), .AR_DATA(AR_DATA),
        .MBOX_RESP(MBOX_RESP), .MBOX_DATA(MBOX_DATA), .AR_LOAD(AR_LOAD),
        .ARX_LOAD(ARX_LOAD), .FETCH_DONE(FETCH_DONE), .PAGE_FAIL(PAGE_FAIL),
        .NXM(NXM), .BUSY(BUSY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
        .MEM_RDATA(MEM_RDATA)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Expected event: ev = {NXM, PAGE_FAIL, MBOX_RESP}
    typedef struct {
        logic [2:0]    ev;
        logic [DW-1:0] data;
        logic          ar;
        logic          arx;
        logic          fetch;
        int            at;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic expect_ev(input logic [2:0] ev, input logic [DW-1:0] d,
                             input logic ar, input logic arx, input logic f, input int lat);
        exp_t e;
        e.ev = ev; e.data = d; e.ar = ar; e.arx = arx; e.fetch = f; e.at = cycle + lat;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        MBOX_CYC_REQ = 0; VMA_READ = 0; VMA_WRITE = 0; VMA_PAUSE = 0;
        LOAD_AR = 0; LOAD_ARX = 0; VMA_FETCH = 0; VMA_ADR_ERR = 0;
    endtask

    // Monitor: every completion-type output is matched against the scoreboard
    always @(negedge clk) begin
        if (mon_en && !RESET) begin
            if ({NXM, PAGE_FAIL, MBOX_RESP} != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {NXM, PAGE_FAIL, MBOX_RESP}, 3'b000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_kind", {NXM, PAGE_FAIL, MBOX_RESP}, e.ev);
                    chk("event_cycle", cycle, e.at);
                    chk("event_data", MBOX_DATA, e.data);
                    chk("event_strobes", {AR_LOAD, ARX_LOAD, FETCH_DONE}, {e.ar, e.arx, e.fetch});
                end
            end else begin
                chk("idle_strobes", {AR_LOAD, ARX_LOAD, FETCH_DONE}, 3'b000);
            end
        end
    end

    initial begin
        RESET = 1; clear_req(); VMA = '0; AR_DATA = '0; MEM_ACK = 0; MEM_RDATA = '0;
        tick(3);
        chk("reset_ctl", {MBOX_RESP, AR_LOAD, ARX_LOAD, FETCH_DONE, PAGE_FAIL, NXM, BUSY, MEM_REQ, MEM_WE}, 9'b0);
        chk("reset_data", MBOX_DATA, 0);
        chk("reset_addr", MEM_ADDR, 0);
        chk("reset_wdata", MEM_WDATA, 0);
        RESET = 0; mon_en = 1'b1;
        tick(2);

        // Read, ack 3 cycles after MEM_REQ rises, request during busy ignored
        VMA = 23'o4000; VMA_READ = 1; LOAD_AR = 1; MBOX_CYC_REQ = 1;
        expect_ev(3'b001, 36'o123456701234, 1, 0, 0, 5);
        tick(1); clear_req();
        chk("rd_ctl", {MEM_REQ, MEM_WE, BUSY}, 3'b101);
        MBOX_CYC_REQ = 1; VMA_WRITE = 1; VMA = 23'o7;
        tick(1); clear_req();
        chk("busy_ignore_ctl", {MEM_REQ, MEM_WE}, 2'b10);
        chk("busy_ignore_addr", MEM_ADDR, 23'o4000);
        tick(2); MEM_ACK = 1; MEM_RDATA = 36'o123456701234;
        tick(1); MEM_ACK = 0; MEM_RDATA = '0;
        chk("rd_req_drop", MEM_REQ, 0);
        tick(1);
        chk("rd_idle", BUSY, 0);

        // Zero-wait write
        VMA = 23'o1000; AR_DATA = 36'o777; VMA_WRITE = 1; MBOX_CYC_REQ = 1;
        expect_ev(3'b001, 36'o123456701234, 0, 0, 0, 2);
        tick(1); clear_req(); MEM_ACK = 1;
        chk("wr_ctl", {MEM_REQ, MEM_WE}, 2'b11);
        chk("wr_addr", MEM_ADDR, 23'o1000);
        chk("wr_wdata", MEM_WDATA, 36'o777);
        tick(1); MEM_ACK = 0;
        chk("wr_done", {MEM_REQ, MEM_WE}, 2'b00);
        tick(1);

        // Read-pause-write: write uses the first address, second VMA and ADR_ERR ignored
        VMA = 23'o200; AR_DATA = 36'o11; VMA_READ = 1; VMA_WRITE = 1; VMA_PAUSE = 1;
        LOAD_ARX = 1; MBOX_CYC_REQ = 1;
        expect_ev(3'b001, 36'o5, 0, 1, 0, 2);
        tick(1); clear_req(); MEM_ACK = 1; MEM_RDATA = 36'o5;
        chk("rpw_rd_ctl", {MEM_REQ, MEM_WE}, 2'b10);
        chk("rpw_rd_addr", MEM_ADDR, 23'o200);
        tick(1); MEM_ACK = 0; MEM_RDATA = '0;
        tick(1);
        chk("rpw_paused", {BUSY, MEM_REQ}, 2'b00);
        tick(1);
        chk("rpw_paused_hold", {BUSY, MEM_REQ}, 2'b00);
        VMA = 23'o300; AR_DATA = 36'o6; VMA_WRITE = 1; VMA_ADR_ERR = 1; MBOX_CYC_REQ = 1;
        expect_ev(3'b001, 36'o5, 0, 0, 0, 2);
        tick(1); clear_req(); MEM_ACK = 1;
        chk("rpw_wr_ctl", {MEM_REQ, MEM_WE}, 2'b11);
        chk("rpw_wr_addr", MEM_ADDR, 23'o200);
        chk("rpw_wr_data", MEM_WDATA, 36'o6);
        tick(1); MEM_ACK = 0;
        tick(1);

        // Zero-wait fetch with both load strobes
        VMA = 23'o5; VMA_READ = 1; LOAD_AR = 1; LOAD_ARX = 1; VMA_FETCH = 1; MBOX_CYC_REQ = 1;
        expect_ev(3'b001, 36'o777777000001, 1, 1, 1, 2);
        tick(1); clear_req(); MEM_ACK = 1; MEM_RDATA = 36'o777777000001;
        tick(1); MEM_ACK = 0; MEM_RDATA = '0;
        tick(1);

        // Address error on a read: page fail, no memory access
        VMA = 23'o2; VMA_READ = 1; VMA_ADR_ERR = 1; MBOX_CYC_REQ = 1;
        expect_ev(3'b010, 36'o777777000001, 0, 0, 0, 1);
        tick(1); clear_req();
        chk("pf_noreq", MEM_REQ, 0);
        tick(1);
        chk("pf_done", {MEM_REQ, BUSY}, 2'b00);
        tick(1);

        // No cycle-type flag: bare response next cycle, data unchanged
        VMA = 23'o3; LOAD_AR = 1; MBOX_CYC_REQ = 1;
        expect_ev(3'b001, 36'o777777000001, 0, 0, 0, 1);
        tick(1); clear_req();
        chk("nop_noreq", MEM_REQ, 0);
        tick(1);
        chk("nop_idle", BUSY, 0);

        // Stray acknowledge while idle
        MEM_ACK = 1; MEM_RDATA = 36'o1;
        tick(1); MEM_ACK = 0; MEM_RDATA = '0;
        tick(1);
        chk("stray_ack_data", MBOX_DATA, 36'o777777000001);
        chk("stray_ack_busy", BUSY, 0);

        // Reset while a write is waiting on memory
        VMA = 23'o17; AR_DATA = 36'o42; VMA_WRITE = 1; MBOX_CYC_REQ = 1;
        tick(1); clear_req();
        chk("rst_pre", {MEM_REQ, MEM_WE}, 2'b11);
        tick(1);
        RESET = 1;
        tick(1); RESET = 0;
        chk("rst_ctl", {MEM_REQ, MEM_WE, BUSY}, 3'b000);
        chk("rst_data", MBOX_DATA, 0);
        chk("rst_addr", MEM_ADDR, 0);
        MEM_ACK = 1;
        tick(1); MEM_ACK = 0;
        chk("rst_ack_ignored", {MEM_REQ, BUSY}, 2'b00);
        tick(2);

`ifdef MBOX_NXM_TIMEOUT_EN
        // Read never acknowledged: NXM after 4 wait cycles, data all ones, no response
        VMA = 23'o3; VMA_READ = 1; MBOX_CYC_REQ = 1;
        expect_ev(3'b100, {DW{1'b1}}, 0, 0, 0, 5);
        tick(1); clear_req();
        tick(4);
        chk("nxm_req_drop", {MEM_REQ, BUSY}, 2'b00);
        tick(1);
        chk("nxm_idle", BUSY, 0);
`endif

        tick(3);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
